// File: rtl/wb_pipe_stage.sv
// MEM->WB pipeline register: LANES writeback bundles carried through DEPTH
// register stages, with stall hold, flush (bubble into stage 0) and a
// youngest-first forwarding lookup across every stage and lane.

// One lane's DEPTH-deep shift register plus its per-stage forwarding match.
module wb_pipe_lane #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic                          flush,
  input  logic [ADDR_W-1:0]             in_addr,
  input  logic                          in_we,
  input  logic [DATA_W-1:0]             in_data,
  input  logic [ADDR_W-1:0]             fwd_addr,
  output logic [ADDR_W-1:0]             out_addr,
  output logic                          out_we,
  output logic [DATA_W-1:0]             out_data,
  output logic [DEPTH-1:0]              stg_hit,
  output logic [DEPTH-1:0][DATA_W-1:0]  stg_data
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t [DEPTH-1:0] stg_q;

  // Shift entries toward WB; stage 0 takes a bubble on flush, and a write
  // to register 0 is stored with we cleared so it can never hit or retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_q <= '0;
    end else if (!stall) begin
      if (flush) begin
        stg_q[0] <= '0;
      end else begin
        stg_q[0].addr <= in_addr;
        stg_q[0].we   <= in_we && (in_addr != '0);
        stg_q[0].data <= in_data;
      end
      for (int k = 1; k < DEPTH; k++)
        stg_q[k] <= stg_q[k-1];
    end
  end

  // Per-stage live-write match against the query address.
  always_comb begin
    stg_hit  = '0;
    stg_data = '0;
    for (int s = 0; s < DEPTH; s++) begin
      stg_hit[s]  = stg_q[s].we && (stg_q[s].addr == fwd_addr) && (fwd_addr != '0);
      stg_data[s] = stg_q[s].data;
    end
  end

  assign out_addr = stg_q[DEPTH-1].addr;
  assign out_we   = stg_q[DEPTH-1].we;
  assign out_data = stg_q[DEPTH-1].data;

endmodule

module wb_pipe_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int LANES  = 1,
  parameter int DEPTH  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    flush,
  input  logic [LANES*ADDR_W-1:0] mem_write_reg,
  input  logic [LANES-1:0]        mem_we,
  input  logic [LANES*DATA_W-1:0] mem_write_data,
  output logic [LANES*ADDR_W-1:0] wb_write_reg,
  output logic [LANES-1:0]        wb_we,
  output logic [LANES*DATA_W-1:0] wb_write_data,
  input  logic [ADDR_W-1:0]       fwd_addr,
  output logic                    fwd_hit,
  output logic [DATA_W-1:0]       fwd_data
);

  logic [LANES-1:0][DEPTH-1:0]             hit_m;
  logic [LANES-1:0][DEPTH-1:0][DATA_W-1:0] data_m;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    wb_pipe_lane #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .DEPTH (DEPTH)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .stall   (stall),
      .flush   (flush),
      .in_addr (mem_write_reg[l*ADDR_W +: ADDR_W]),
      .in_we   (mem_we[l]),
      .in_data (mem_write_data[l*DATA_W +: DATA_W]),
      .fwd_addr(fwd_addr),
      .out_addr(wb_write_reg[l*ADDR_W +: ADDR_W]),
      .out_we  (wb_we[l]),
      .out_data(wb_write_data[l*DATA_W +: DATA_W]),
      .stg_hit (hit_m[l]),
      .stg_data(data_m[l])
    );
  end

  // Priority select: scan oldest->youngest and low->high lane so the last
  // assignment (youngest stage, highest lane) wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int s = DEPTH-1; s >= 0; s--) begin
      for (int l = 0; l < LANES; l++) begin
        if (hit_m[l][s]) begin
          fwd_hit  = 1'b1;
          fwd_data = data_m[l][s];
        end
      end
    end
  end

endmodule
